// File: rtl/tile_array_scheduler.sv
// Round-robin job dispatcher and result collector for a TILE-wide PE array.
// Results leave through a single registered valid/ready stream tagged with the tile index.
module tile_array_scheduler #(
   parameter int TILE   = 4,
   parameter int DATA_W = 20,
   parameter int JOB_W  = 16,
   parameter int TILE_W = (TILE > 1) ? $clog2(TILE) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_start,
   input  logic [TILE-1:0]          cfg_tile_mask,
   input  logic [JOB_W-1:0]         cfg_num_jobs,
   input  logic                     abort,
   output logic [TILE-1:0]          tile_start,
   input  logic [TILE-1:0]          tile_done,
   input  logic [TILE*DATA_W-1:0]   tile_data,
   output logic [TILE-1:0]          tile_taken,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [TILE_W-1:0]        out_tile,
   output logic                     busy,
   output logic                     done,
   output logic                     err_cfg,
   output logic                     err_spurious
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic              hit;
      logic [TILE_W-1:0] idx;
   } pick_t;

   // First requesting index at or after base, wrapping modulo TILE.
   function automatic pick_t rr_pick(input logic [TILE-1:0] req, input logic [TILE_W-1:0] base);
      pick_t res;
      int    p;
      res = '0;
      for (int i = 0; i < TILE; i++) begin
         p = int'(base) + i;
         if (p >= TILE) p -= TILE;
         if (!res.hit && req[p]) begin
            res.hit = 1'b1;
            res.idx = TILE_W'(p);
         end
      end
      return res;
   endfunction

   function automatic logic [TILE_W-1:0] rr_next(input logic [TILE_W-1:0] idx);
      return (int'(idx) == TILE - 1) ? '0 : idx + 1'b1;
   endfunction

   state_t            state;
   logic [TILE-1:0]   mask_q;
   logic [TILE-1:0]   busy_mask;
   logic [JOB_W-1:0]  num_jobs_q;
   logic [JOB_W-1:0]  issued;
   logic [JOB_W-1:0]  retired;
   logic [TILE_W-1:0] rr_issue;
   logic [TILE_W-1:0] rr_take;

   logic              cfg_accept;
   logic              cfg_bad;
   logic              cfg_go;
   logic [TILE-1:0]   issue_mask;
   logic              issue_open;
   pick_t             issue_pick;
   logic              issue_fire;
   logic [TILE-1:0]   issue_oh;
   logic              take_open;
   pick_t             take_pick;
   logic              take_fire;
   logic [DATA_W-1:0] take_data;
   logic              spurious_hit;

   always_comb begin
      // NOTE: every signal driven here is assigned on all paths, so no latch can be inferred.
      cfg_accept   = (state == IDLE) && cfg_start;
      cfg_bad      = (cfg_tile_mask == '0);
      cfg_go       = cfg_accept && !cfg_bad && (cfg_num_jobs != '0);

      // The accepting edge dispatches from the live config; later edges use the held copy.
      issue_mask   = cfg_accept ? cfg_tile_mask : mask_q;
      issue_open   = cfg_go || ((state == RUN) && (issued < num_jobs_q));
      issue_pick   = rr_pick(issue_mask & ~busy_mask, rr_issue);
      issue_fire   = issue_open && issue_pick.hit;
      issue_oh     = issue_fire ? (TILE'(1) << issue_pick.idx) : '0;

      take_open    = ((state == RUN) || (state == DRAIN)) && (!out_valid || out_ready) && !abort;
      take_pick    = rr_pick(tile_done & busy_mask, rr_take);
      take_fire    = take_open && take_pick.hit;
      tile_taken   = take_fire ? (TILE'(1) << take_pick.idx) : '0;
      take_data    = tile_data[int'(take_pick.idx) * DATA_W +: DATA_W];

      spurious_hit = |(tile_done & ~busy_mask);
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous; every register, including the config copies, is cleared.
      if (reset) begin
         state        <= IDLE;
         mask_q       <= '0;
         num_jobs_q   <= '0;
         busy_mask    <= '0;
         issued       <= '0;
         retired      <= '0;
         rr_issue     <= '0;
         rr_take      <= '0;
         tile_start   <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_tile     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_cfg      <= 1'b0;
         err_spurious <= 1'b0;
      end else if (abort) begin
         state      <= IDLE;
         busy_mask  <= '0;
         issued     <= '0;
         retired    <= '0;
         tile_start <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         tile_start <= issue_oh;
         done       <= 1'b0;
         busy_mask  <= (busy_mask & ~tile_taken) | issue_oh;

         if (issue_fire) begin
            issued   <= cfg_accept ? JOB_W'(1) : issued + JOB_W'(1);
            rr_issue <= rr_next(issue_pick.idx);
         end else if (cfg_accept) begin
            issued <= '0;
         end

         if (cfg_accept)     retired <= '0;
         else if (take_fire) retired <= retired + JOB_W'(1);

         if (take_fire) begin
            out_valid <= 1'b1;
            out_data  <= take_data;
            out_tile  <= take_pick.idx;
            rr_take   <= rr_next(take_pick.idx);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         err_spurious <= (err_spurious && !cfg_accept) || spurious_hit;

         case (state)
            IDLE: begin
               if (cfg_accept) begin
                  mask_q     <= cfg_tile_mask;
                  num_jobs_q <= cfg_num_jobs;
                  err_cfg    <= cfg_bad && (cfg_num_jobs != '0);
                  busy       <= 1'b1;
                  if (cfg_go) begin
                     state <= RUN;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issued == num_jobs_q) state <= DRAIN;
            end
            DRAIN: begin
               // Leave as the last result transfers, so done follows the final handshake directly.
               if ((retired == num_jobs_q) && (!out_valid || out_ready)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_array_scheduler.sv
// Directed bench: batch table plus hand sequences for arbitration, stall, abort and spurious done.
// Tiles are modelled as fixed 3-cycle responders that hold done until acknowledged.
module tb_tile_array_scheduler;

   localparam int TILE   = 4;
   localparam int DATA_W = 20;
   localparam int JOB_W  = 16;
   localparam int TILE_W = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   cfg_start;
   logic [TILE-1:0]        cfg_tile_mask;
   logic [JOB_W-1:0]       cfg_num_jobs;
   logic                   abort;
   logic [TILE-1:0]        tile_start;
   logic [TILE-1:0]        tile_done;
   logic [TILE*DATA_W-1:0] tile_data;
   logic [TILE-1:0]        tile_taken;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_W-1:0]      out_data;
   logic [TILE_W-1:0]      out_tile;
   logic                   busy;
   logic                   done;
   logic                   err_cfg;
   logic                   err_spurious;

   tile_array_scheduler #(.TILE(TILE), .DATA_W(DATA_W), .JOB_W(JOB_W), .TILE_W(TILE_W)) dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_tile_mask(cfg_tile_mask),
      .cfg_num_jobs(cfg_num_jobs), .abort(abort), .tile_start(tile_start), .tile_done(tile_done),
      .tile_data(tile_data), .tile_taken(tile_taken), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tile(out_tile), .busy(busy), .done(done), .err_cfg(err_cfg),
      .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TILE-1:0] mask;
      int              jobs;
      int              spur;          // tile to pulse tile_done on right after cfg, -1 for none
      bit              exp_err_cfg;
      bit              exp_err_spur;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit auto_tiles;
   int cnt  [TILE];
   int pend [TILE];
   int seq;
   int exp_rr;
   int start_log[$], start_cyc[$], taken_log[$], taken_cyc[$];
   int xfer_tile[$], xfer_data[$], exp_data[$];
   int done_cnt, done_cyc, last_xfer_cyc;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic clear_logs();
      start_log.delete(); start_cyc.delete(); taken_log.delete(); taken_cyc.delete();
      xfer_tile.delete(); xfer_data.delete(); exp_data.delete();
      done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1;
   endtask

   // Observe at negedge, then advance the tile model just after the rising edge.
   task automatic tick();
      logic [TILE-1:0] s_start, s_taken;
      @(negedge clk);
      cyc++;
      s_start = tile_start;
      s_taken = tile_taken;
      for (int k = 0; k < TILE; k++) begin
         if (s_start[k]) begin start_log.push_back(k); start_cyc.push_back(cyc); end
         if (s_taken[k]) begin taken_log.push_back(k); taken_cyc.push_back(cyc); end
      end
      if (out_valid && out_ready) begin
         xfer_tile.push_back(int'(out_tile));
         xfer_data.push_back(int'(out_data));
         last_xfer_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      @(posedge clk);
      #1;
      for (int k = 0; k < TILE; k++) begin
         if (s_taken[k]) tile_done[k] = 1'b0;
         if (auto_tiles) begin
            if (s_start[k]) begin
               cnt[k]  = 2;
               pend[k] = k * 4096 + seq;
               exp_data.push_back(pend[k]);
               seq = (seq + 1) % 4096;
            end else if (cnt[k] > 0) begin
               cnt[k]--;
               if (cnt[k] == 0) begin
                  tile_done[k] = 1'b1;
                  tile_data[k*DATA_W +: DATA_W] = DATA_W'(pend[k]);
               end
            end
         end
      end
   endtask

   task automatic quiet_tiles();
      for (int k = 0; k < TILE; k++) cnt[k] = 0;
      tile_done = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1; cfg_start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      cfg_tile_mask = '0; cfg_num_jobs = '0; tile_data = '0;
      quiet_tiles();
      tick();
      tick();
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) tick();
      check({name, " done pulse seen"}, done_cnt, 1);
   endtask

   task automatic run_batch(input vec_t v, input string name);
      int exp_s[$];
      int p, cfg_cyc, n_exp, n_take3;
      clear_logs();
      p = exp_rr;
      if (v.mask != '0 && v.jobs > 0) begin
         for (int j = 0; j < v.jobs; j++) begin
            while (!v.mask[p]) p = (p + 1) % TILE;
            exp_s.push_back(p);
            p = (p + 1) % TILE;
         end
      end
      auto_tiles = 1'b1;
      out_ready  = 1'b1;
      cfg_tile_mask = v.mask;
      cfg_num_jobs  = JOB_W'(v.jobs);
      cfg_start     = 1'b1;
      tick();
      cfg_cyc = cyc;
      cfg_start = 1'b0; cfg_tile_mask = '0; cfg_num_jobs = '0;
      if (v.spur >= 0) begin
         tile_done[v.spur] = 1'b1;
         tick();
         tile_done[v.spur] = 1'b0;
      end
      wait_done(name, 400);
      check({name, " done is one cycle"}, int'(done), 0);
      check({name, " busy after done"}, int'(busy), 0);
      n_exp = exp_s.size();
      check({name, " start count"}, start_log.size(), n_exp);
      for (int i = 0; i < n_exp && i < start_log.size(); i++)
         check($sformatf("%s start %0d tile", name, i), start_log[i], exp_s[i]);
      if (n_exp > 0 && start_cyc.size() > 0)
         check({name, " first start latency"}, start_cyc[0] - cfg_cyc, 1);
      check({name, " result count"}, xfer_tile.size(), n_exp);
      for (int i = 0; i < n_exp && i < xfer_tile.size(); i++) begin
         check($sformatf("%s result %0d tile", name, i), xfer_tile[i], exp_s[i]);
         if (i < exp_data.size())
            check($sformatf("%s result %0d data", name, i), xfer_data[i], exp_data[i]);
      end
      if (n_exp > 0) check({name, " done after last transfer"}, done_cyc - last_xfer_cyc, 1);
      else           check({name, " done after cfg"}, done_cyc - cfg_cyc, 1);
      check({name, " err_cfg"}, int'(err_cfg), int'(v.exp_err_cfg));
      check({name, " err_spurious"}, int'(err_spurious), int'(v.exp_err_spur));
      n_take3 = 0;
      foreach (taken_log[i]) if (taken_log[i] == 3 && !v.mask[3]) n_take3++;
      check({name, " no ack of unmasked tile 3"}, n_take3, 0);
      exp_rr = p;
   endtask

   initial begin
      vec_t vecs[6];
      vecs[0] = '{mask: 4'b1111, jobs: 8, spur: -1, exp_err_cfg: 1'b0, exp_err_spur: 1'b0};
      vecs[1] = '{mask: 4'b0101, jobs: 5, spur: -1, exp_err_cfg: 1'b0, exp_err_spur: 1'b0};
      vecs[2] = '{mask: 4'b1111, jobs: 0, spur: -1, exp_err_cfg: 1'b0, exp_err_spur: 1'b0};
      vecs[3] = '{mask: 4'b0000, jobs: 3, spur: -1, exp_err_cfg: 1'b1, exp_err_spur: 1'b0};
      vecs[4] = '{mask: 4'b0010, jobs: 3, spur: -1, exp_err_cfg: 1'b0, exp_err_spur: 1'b0};
      vecs[5] = '{mask: 4'b1011, jobs: 6, spur: -1, exp_err_cfg: 1'b0, exp_err_spur: 1'b0};
      seq = 1;
      auto_tiles = 1'b0;

      do_reset();
      check("reset tile_start", int'(tile_start), 0);
      check("reset tile_taken", int'(tile_taken), 0);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_data", int'(out_data), 0);
      check("reset out_tile", int'(out_tile), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset err_cfg", int'(err_cfg), 0);
      check("reset err_spurious", int'(err_spurious), 0);
      reset = 1'b0;
      exp_rr = 0;
      tick();

      for (int i = 0; i < 6; i++) run_batch(vecs[i], $sformatf("vec%0d", i));

      // All four tiles report together: back-to-back acks, then a held output under stall.
      do_reset();
      reset = 1'b0;
      clear_logs();
      auto_tiles = 1'b0;
      cfg_tile_mask = 4'b1111; cfg_num_jobs = JOB_W'(8); cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < 20 && start_log.size() < 4; i++) tick();
      check("arb first starts", start_log.size(), 4);
      tile_done = 4'b1111;
      for (int k = 0; k < TILE; k++) tile_data[k*DATA_W +: DATA_W] = DATA_W'('h100 + k);
      for (int i = 0; i < 20 && taken_log.size() < 4; i++) tick();
      check("arb taken count", taken_log.size(), 4);
      for (int i = 0; i < 4 && i < taken_log.size(); i++) begin
         check($sformatf("arb taken %0d tile", i), taken_log[i], i);
         check($sformatf("arb taken %0d cycle", i), taken_cyc[i] - taken_cyc[0], i);
      end
      for (int i = 0; i < 40 && start_log.size() < 8; i++) tick();
      check("arb restarts", start_log.size(), 8);
      out_ready = 1'b0;
      tile_done = 4'b1111;
      for (int k = 0; k < TILE; k++) tile_data[k*DATA_W +: DATA_W] = DATA_W'('h200 + k);
      tick();
      check("stall first capture", taken_log.size(), 5);
      if (taken_log.size() >= 5) check("stall first capture tile", taken_log[4], 0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall %0d out_valid", i), int'(out_valid), 1);
         check($sformatf("stall %0d out_data", i), int'(out_data), 'h200);
         tick();
      end
      check("stall no acks", taken_log.size(), 5);
      out_ready = 1'b1;
      wait_done("arb", 100);
      check("arb result count", xfer_tile.size(), 8);
      for (int i = 0; i < 8 && i < xfer_tile.size(); i++) begin
         check($sformatf("arb result %0d tile", i), xfer_tile[i], i % 4);
         check($sformatf("arb result %0d data", i), xfer_data[i], (i < 4) ? ('h100 + i) : ('h200 + i - 4));
      end

      // Abort with two tiles running, then a clean batch.
      do_reset();
      reset = 1'b0;
      exp_rr = 0;
      clear_logs();
      auto_tiles = 1'b1;
      cfg_tile_mask = 4'b1111; cfg_num_jobs = JOB_W'(8); cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      tick();
      check("abort one start seen", start_log.size(), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      quiet_tiles();
      check("abort busy", int'(busy), 0);
      check("abort out_valid", int'(out_valid), 0);
      check("abort tile_start", int'(tile_start), 0);
      check("abort starts issued", start_log.size(), 2);
      for (int i = 0; i < 2 && i < start_log.size(); i++)
         check($sformatf("abort start %0d tile", i), start_log[i], i);
      for (int i = 0; i < 5; i++) tick();
      check("abort no done", done_cnt, 0);
      check("abort no acks", taken_log.size(), 0);
      exp_rr = 2;
      run_batch('{mask: 4'b0011, jobs: 4, spur: -1, exp_err_cfg: 1'b0, exp_err_spur: 1'b0}, "post_abort");

      // Spurious done from an idle tile sets a sticky flag cleared only by the next cfg_start.
      run_batch('{mask: 4'b0111, jobs: 3, spur: 3, exp_err_cfg: 1'b0, exp_err_spur: 1'b1}, "spur");
      for (int i = 0; i < 3; i++) tick();
      check("spur flag sticky in idle", int'(err_spurious), 1);
      run_batch('{mask: 4'b0001, jobs: 0, spur: -1, exp_err_cfg: 1'b0, exp_err_spur: 1'b0}, "spur_clear");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
